// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit direction counter,
// BTB entry layout and the saturating counter step function.
package branch_predictor_pkg;

  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] uintx_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Tag is held right-justified at full width; the constant-zero upper bits
  // are trimmed by synthesis, which keeps this struct independent of ENTRIES.
  typedef struct packed {
    logic   valid;
    uintx_t tag;
    uintx_t target;
    ctr_t   ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating direction counter next-state logic, shared with any
// future history-table predictor.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  assign o_ctr = ctr_next(i_ctr, i_taken);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counter. Lookup is
// combinational and reads pre-update state; updates and flush are registered.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_pred_hit,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_flush
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t r_btb [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  uintx_t           w_lk_tag;
  uintx_t           w_up_tag;
  btb_entry_t       w_lk_ent;
  btb_entry_t       w_up_ent;
  logic             w_up_hit;
  ctr_t             w_up_ctr_next;

  // Instructions are 4-byte aligned, so pc[1:0] never selects anything.
  assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag = uintx_t'(i_lookup_pc >> (IDX_W + 2));
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = uintx_t'(i_upd_pc >> (IDX_W + 2));

  assign w_lk_ent = r_btb[w_lk_idx];
  assign w_up_ent = r_btb[w_up_idx];

  assign o_pred_hit    = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
  assign o_pred_taken  = o_pred_hit && w_lk_ent.ctr[1];
  assign o_pred_target = o_pred_hit ? w_lk_ent.target : '0;

  assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

  bp_sat_counter u_sat_counter (
    .i_ctr   (w_up_ent.ctr),
    .i_taken (i_upd_taken),
    .o_ctr   (w_up_ctr_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (i_flush) begin
      // Counters survive a flush; only allocation re-seeds them.
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i].valid <= 1'b0;
      end
    end else if (i_upd_valid) begin
      if (w_up_hit) begin
        r_btb[w_up_idx].ctr <= w_up_ctr_next;
        if (i_upd_taken) r_btb[w_up_idx].target <= i_upd_target;
      end else if (i_upd_taken) begin
        r_btb[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: i_upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expected
// lookup results, a monitor pops and compares them away from the clock edge.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] i_lookup_pc;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_flush;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_pc   (i_lookup_pc),
    .o_pred_hit    (o_pred_hit),
    .o_pred_taken  (o_pred_taken),
    .o_pred_target (o_pred_target),
    .i_upd_valid   (i_upd_valid),
    .i_upd_pc      (i_upd_pc),
    .i_upd_taken   (i_upd_taken),
    .i_upd_target  (i_upd_target),
    .i_flush       (i_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk       = 1'b0;
  logic async_chk = 1'b0;

  localparam logic [31:0] PC10 = 32'h8000_0010;
  localparam logic [31:0] PC20 = 32'h8000_0020;
  localparam logic [31:0] PC30 = 32'h8000_0030;
  localparam logic [31:0] PC50 = 32'h8000_0050;
  localparam logic [31:0] JUNK = 32'hDEAD_0000;

  always @(negedge clk or posedge async_chk) begin
    if (chk || async_chk) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got hit=%0b taken=%0b target=%h, nothing expected",
                 o_pred_hit, o_pred_taken, o_pred_target);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_pred_hit !== mon_e.hit || o_pred_taken !== mon_e.taken || o_pred_target !== mon_e.tgt) begin
          n_fail++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
                   mon_e.nm, o_pred_hit, o_pred_taken, o_pred_target, mon_e.hit, mon_e.taken, mon_e.tgt);
        end
      end
    end
  end

  // One clock cycle: drive update/flush/lookup, expect the lookup result
  // that is visible before the coming posedge.
  task automatic step(input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic fl, input logic [31:0] lpc,
                      input logic eh, input logic et, input logic [31:0] etgt, input string nm);
    exp_t e;
    i_upd_valid  = uv;
    i_upd_pc     = upc;
    i_upd_taken  = ut;
    i_upd_target = utgt;
    i_flush      = fl;
    i_lookup_pc  = lpc;
    e.hit = eh; e.taken = et; e.tgt = etgt; e.nm = nm;
    exp_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk          = 1'b0;
    i_upd_valid  = 1'b0;
    i_flush      = 1'b0;
  endtask

  task automatic lk(input logic [31:0] lpc, input logic eh, input logic et,
                    input logic [31:0] etgt, input string nm);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lpc, eh, et, etgt, nm);
  endtask

  initial begin
    exp_t e;
    rst          = 1'b0;
    i_lookup_pc  = '0;
    i_upd_valid  = 1'b0;
    i_upd_pc     = '0;
    i_upd_taken  = 1'b0;
    i_upd_target = '0;
    i_flush      = 1'b0;
    @(posedge clk);
    #1;
    lk(PC10, 0, 0, 32'h0, "in_reset");
    rst = 1'b1;
    lk(PC10, 0, 0, 32'h0, "after_reset");

    step(1, PC10, 1, 32'h8000_0100, 0, PC10, 0, 0, 32'h0, "alloc_same_cycle");
    lk(PC10, 1, 1, 32'h8000_0100, "alloc_next_cycle");

    // Counter walk down; not-taken updates must not touch the target.
    step(1, PC10, 0, JUNK, 0, PC10, 1, 1, 32'h8000_0100, "nt1_pre");
    step(1, PC10, 0, JUNK, 0, PC10, 1, 0, 32'h8000_0100, "nt2_pre_ctr01");
    step(1, PC10, 0, JUNK, 0, PC10, 1, 0, 32'h8000_0100, "nt3_pre_ctr00");
    lk(PC10, 1, 0, 32'h8000_0100, "ctr00_sat");

    // Counter walk up from 00 with a new target.
    step(1, PC10, 1, 32'h8000_0180, 0, PC10, 1, 0, 32'h8000_0100, "t1_pre_ctr00");
    step(1, PC10, 1, 32'h8000_0180, 0, PC10, 1, 0, 32'h8000_0180, "t2_pre_ctr01");
    step(1, PC10, 1, 32'h8000_0180, 0, PC10, 1, 1, 32'h8000_0180, "t3_pre_ctr10");
    step(1, PC10, 1, 32'h8000_0180, 0, PC10, 1, 1, 32'h8000_0180, "t4_pre_ctr11");
    step(1, PC10, 0, JUNK,          0, PC10, 1, 1, 32'h8000_0180, "ctr11_sat");
    lk(PC10, 1, 1, 32'h8000_0180, "ctr11_minus1");

    // Aliasing at index 4.
    step(1, PC50, 1, 32'h8000_0200, 0, PC50, 0, 0, 32'h0, "alias_same_cycle");
    lk(PC10, 0, 0, 32'h0, "alias_evicted");
    lk(PC50, 1, 1, 32'h8000_0200, "alias_hit");
    step(1, PC50, 0, JUNK, 0, PC50, 1, 1, 32'h8000_0200, "alias_nt1");
    step(1, PC50, 0, JUNK, 0, PC50, 1, 0, 32'h8000_0200, "alias_nt2");
    lk(PC50, 1, 0, 32'h8000_0200, "alias_ctr00");

    // Miss + not-taken allocates nothing.
    step(1, PC20, 0, 32'h8000_0300, 0, PC20, 0, 0, 32'h0, "miss_nt_same");
    lk(PC20, 0, 0, 32'h0, "miss_nt_no_alloc");

    // Allocation reseeds the counter to weak-taken over a 00 occupant.
    step(1, PC10, 1, 32'h8000_0110, 0, PC10, 0, 0, 32'h0, "realloc_same");
    lk(PC10, 1, 1, 32'h8000_0110, "realloc_ctr10");

    step(1, PC20, 1, 32'h8000_0220, 0, PC20, 0, 0, 32'h0, "alloc20_same");
    lk(PC20, 1, 1, 32'h8000_0220, "alloc20_hit");

    // Flush beats a concurrent update.
    step(1, PC30, 1, 32'h8000_0400, 1, PC10, 1, 1, 32'h8000_0110, "flush_same_cycle");
    lk(PC10, 0, 0, 32'h0, "flush_pc10");
    lk(PC20, 0, 0, 32'h0, "flush_pc20");
    lk(PC30, 0, 0, 32'h0, "flush_upd_dropped");

    step(1, PC10, 1, 32'h8000_0510, 0, PC10, 0, 0, 32'h0, "pre_rst_alloc");
    lk(PC10, 1, 1, 32'h8000_0510, "pre_rst_hit");

    // Asynchronous reset mid-cycle with an update pending.
    rst          = 1'b0;
    i_upd_valid  = 1'b1;
    i_upd_pc     = PC30;
    i_upd_taken  = 1'b1;
    i_upd_target = 32'h8000_0600;
    i_lookup_pc  = PC10;
    e.hit = 1'b0; e.taken = 1'b0; e.tgt = 32'h0; e.nm = "async_rst_immediate";
    exp_q.push_back(e);
    #2;
    async_chk = 1'b1;
    #1;
    async_chk = 1'b0;
    @(posedge clk);
    #1;
    i_upd_valid = 1'b0;
    lk(PC10, 0, 0, 32'h0, "rst_held");
    rst = 1'b1;
    lk(PC30, 0, 0, 32'h0, "rst_upd_lost");
    lk(PC10, 0, 0, 32'h0, "rst_pc10_gone");

    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the fetch stage.
- Fetch uses it to guess the direction and target of a conditional branch before the execute-stage branch unit resolves it.
- The branch unit's resolved outcome (taken/not-taken, target) is written back here, closing the loop.
- Direct-mapped BTB with one 2-bit saturating counter per entry; combinational lookup, registered update.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- i_lookup_pc  in  XLEN  PC of the instruction being fetched
- o_pred_hit  out  1  valid entry with matching tag exists for i_lookup_pc
- o_pred_taken  out  1  o_pred_hit and counter[1]==1
- o_pred_target  out  XLEN  stored target; 0 when !o_pred_hit
- i_upd_valid  in  1  a conditional branch resolved this cycle
- i_upd_pc  in  XLEN  PC of the resolved branch
- i_upd_taken  in  1  branch unit's take result
- i_upd_target  in  XLEN  computed branch target (pc + B-imm)
- i_flush  in  1  invalidate all entries (fence.i, context change)

Behaviour:
- Addressing (4-byte instruction alignment):
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry state: valid (1), tag, target (XLEN), ctr (2 bits):
  - 00 strong-not-taken
  - 01 weak-not-taken
  - 10 weak-taken
  - 11 strong-taken
- Reset (rst low, asynchronous):
  - all valid=0, all ctr=01.
  - Tag and target contents are don't-care.
  - Outputs during and after reset: o_pred_hit=0, o_pred_taken=0, o_pred_target=0.
- Lookup: purely combinational, zero latency.
  - Reads state as of the start of the cycle (read-before-write).
  - An update to the same index in the same cycle is not visible until the next cycle.
- Update: registered at posedge clk when i_upd_valid=1.
  - Hit (valid and tag match):
    - taken: ctr = min(ctr+1, 11)
    - not taken: ctr = max(ctr-1, 00)
    - target overwritten with i_upd_target only if taken.
  - Miss and taken: allocate (replace any occupant). valid=1, tag, target written, ctr=10.
  - Miss and not taken: no state change; no allocation.
  - Saturation: 11 + taken stays 11; 00 + not-taken stays 00. No wrap.
- Flush: posedge with i_flush=1 clears all valid bits.
  - Counters keep their values; they are reset only on allocation.
  - Flush and i_upd_valid in the same cycle: flush wins and the update is discarded.
- Reset mid-operation: asynchronous clear regardless of in-flight update; pending update lost.
- No backpressure: update is fire-and-forget, one per cycle maximum.
- i_upd_* are ignored when i_upd_valid=0.
- No X propagation to outputs: o_pred_target is forced to 0 on miss.

Decomposition:
- Shared package (alongside eei/corectrl):
  - typedef for the 2-bit counter
  - constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11
  - BTB entry struct (valid, tag, target, ctr)
  - function ctr_next(ctr, taken) for saturating update
- XLEN and UIntX come from eei.
- One natural sub-module: bp_sat_counter (2-bit saturating counter next-state logic), reusable for a future BHT/gshare.
- The BTB array stays in the top module.

Test Plan:
- Reset, then lookup pc=0x8000_0010 -> hit=0, taken=0, target=0.
- Update pc=0x8000_0010, taken=1, target=0x8000_0100. Next cycle lookup same pc -> hit=1, taken=1 (ctr=10), target=0x8000_0100. Same-cycle lookup -> hit=0.
- Counter walk on pc=0x8000_0010:
  - 3 not-taken updates -> ctr 10→01→00→00; lookup taken=0, hit=1.
  - Then 4 taken updates -> 01,10,11,11; taken=1 from the second update onward.
- Aliasing with ENTRIES=16: 0x8000_0010 and 0x8000_0050 share index 4.
  - Taken update on 0x8000_0050 (target 0x8000_0200) evicts the first.
  - Lookup 0x8000_0010 -> hit=0; lookup 0x8000_0050 -> hit=1, target 0x8000_0200.
- Not-taken update on a miss at pc=0x8000_0020 -> subsequent lookup hit=0; no allocation.
- Flush:
  - i_flush=1 together with i_upd_valid=1 (taken, pc=0x8000_0030) -> all prior hits gone and 0x8000_0030 not allocated.
  - Assert rst low mid-sequence -> outputs 0 immediately, without waiting for clk.
